// File: rtl/adc_serial_reader_pkg.sv
// Package shared by the ADC serial reader slice.
// Holds the FSM state encoding, the default parameter values and the 18-bit
// sample width that the register bank also uses for its POT operand.
package adc_pkg;

  // Width of the controller operand word that carries the POT sample.
  localparam int unsigned POT_W = 18;

  // Default parameter values for adc_serial_reader.
  localparam int unsigned CLK_DIV_DEF    = 4;
  localparam int unsigned FRAME_BITS_DEF = 16;
  localparam int unsigned ADC_BITS_DEF   = 12;
  localparam int unsigned FRAC_SHIFT_DEF = 4;
  localparam int unsigned QUIET_CYC_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    QUIET
  } adc_state_e;

endpackage

// File: rtl/adc_serial_reader_if.sv
// Signal bundle between adc_serial_reader, the external ADC pins and the
// register bank POT input.
//   ena_adc   : conversion request from the controller (level, edge-detected)
//   sdata     : serial data from the ADC
//   cs_n      : ADC chip select, active low
//   sclk      : ADC serial clock, idle high
//   pot       : latest rescaled sample
//   pot_valid : one-cycle strobe when pot updates
//   busy      : reader is running a frame or its quiet gap
// master is the reader side, slave is the controller/ADC side.
interface adc_serial_reader_if;

  logic                       ena_adc;
  logic                       sdata;
  logic                       cs_n;
  logic                       sclk;
  logic [adc_pkg::POT_W-1:0]  pot;
  logic                       pot_valid;
  logic                       busy;

  modport master (
    input  ena_adc,
    input  sdata,
    output cs_n,
    output sclk,
    output pot,
    output pot_valid,
    output busy
  );

  modport slave (
    output ena_adc,
    output sdata,
    input  cs_n,
    input  sclk,
    input  pot,
    input  pot_valid,
    input  busy
  );

endinterface

// File: rtl/adc_serial_reader_sclk_divider.sv
// SCLK generator for the ADC serial reader.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   en        : run the divider; when low it parks in the high phase, count 0
//   sclk      : registered serial clock, CLK_DIV clk cycles per half-period
//   rise_tick : high in the last cycle of a low phase (sclk rises at the next edge)
//   fall_tick : high in the last cycle of a high phase (sclk falls at the next
//               edge if still enabled); also high while parked
module adc_sclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          phase_end;

  // Down-counter: a phase ends when the count is 0. Parking at high/0 makes
  // the first enabled edge drop sclk immediately, so the frame starts with a
  // full-length low phase.
  assign phase_end = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (phase_end) begin
      cnt_d  = CW'(CLK_DIV - 1);
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Ticks are independent of en so the top can use them to decide en
  // without a combinational loop.
  assign rise_tick = phase_end & ~sclk_q;
  assign fall_tick = phase_end &  sclk_q;
  assign sclk      = sclk_q;

endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: answers the controller's Ena_ADC request by running one
// SPI-style read frame on a 12-bit serial ADC and returning the code, scaled
// into the 18-bit operand format, as the POT sample with a valid strobe.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : adc_serial_reader_if.master (ena_adc, sdata in; cs_n, sclk, pot,
//         pot_valid, busy out; all outputs registered)
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned ADC_BITS   = ADC_BITS_DEF,
  parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int unsigned QUIET_CYC  = QUIET_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  adc_serial_reader_if.master bus
);

  localparam int unsigned BCW = $clog2(FRAME_BITS + 1);
  localparam int unsigned QCW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  adc_state_e            state_q, state_d;
  logic                  ena_q, ena_d;
  logic                  ena_prev_q, ena_prev_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [QCW-1:0]        quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0] shifter_q, shifter_d;
  logic                  cs_n_q, cs_n_d;
  logic [POT_W-1:0]      pot_q, pot_d;
  logic                  pot_valid_q, pot_valid_d;
  logic                  busy_q, busy_d;

  logic                  request;
  logic                  sclk_en;
  logic                  sclk;
  logic                  rise_tick;
  logic                  fall_tick;
  logic [POT_W-1:0]      code_scaled;

  assign request = ena_q & ~ena_prev_q;

  // Divider follows the next state so sclk falls together with cs_n on the
  // first SHIFT cycle and is back in its parked high state for DONE.
  assign sclk_en = (state_d == SHIFT);

  adc_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Only the trailing ADC_BITS of the frame carry the code; leading bits drop.
  assign code_scaled = POT_W'(shifter_q[ADC_BITS-1:0]) << FRAC_SHIFT;

  always_comb begin
    state_d     = state_q;
    ena_d       = bus.ena_adc;
    ena_prev_d  = ena_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shifter_d   = shifter_q;

    unique case (state_q)
      IDLE: begin
        if (request) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shifter_d = '0;
        end
      end
      SHIFT: begin
        if (rise_tick) begin
          shifter_d = FRAME_BITS'({shifter_q, bus.sdata});
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // Frame ends after the high phase of the last bit completes.
        if (fall_tick && (bit_cnt_q == BCW'(FRAME_BITS))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d     = QUIET;
        quiet_cnt_d = '0;
      end
      QUIET: begin
        if (quiet_cnt_q == QCW'(QUIET_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_n_d      = (state_d != SHIFT);
    busy_d      = (state_d != IDLE);
    pot_valid_d = (state_d == DONE);
    pot_d       = pot_q;
    if (state_d == DONE) begin
      pot_d = code_scaled;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ena_q       <= 1'b0;
      ena_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shifter_q   <= '0;
      cs_n_q      <= 1'b1;
      pot_q       <= '0;
      pot_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ena_q       <= ena_d;
      ena_prev_q  <= ena_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shifter_q   <= shifter_d;
      cs_n_q      <= cs_n_d;
      pot_q       <= pot_d;
      pot_valid_q <= pot_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cs_n      = cs_n_q;
  assign bus.sclk      = sclk;
  assign bus.pot       = pot_q;
  assign bus.pot_valid = pot_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader. Three instances share clk/rst:
// index 0 uses CLK_DIV=4 (main sequence), 1 uses CLK_DIV=1, 2 uses CLK_DIV=7.
// Each instance has a small ADC model and a pin monitor (sclk edges,
// half-period lengths, cs_n fall cycle, pot_valid count/cycle).
module tb_adc_serial_reader;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [2:0]       ena_drv = '0;
  logic [15:0]      frame_w [3];
  logic [POT_W-1:0] pot_o [3];
  logic             cs_o [3];
  logic             sclk_o [3];
  logic             valid_o [3];
  logic             busy_o [3];
  int               rises_o [3];
  int               minh_o [3];
  int               maxh_o [3];
  int               valids_o [3];
  int               valid_cyc_o [3];
  int               fall_cyc_o [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 4 : ((g == 1) ? 1 : 7);

    adc_serial_reader_if ifc ();

    adc_serial_reader #(
      .CLK_DIV    (DIV),
      .FRAME_BITS (16),
      .ADC_BITS   (12),
      .FRAC_SHIFT (4),
      .QUIET_CYC  (8)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        sd = 1'b0;
    logic [15:0] fr = '0;
    int          rises = 0;
    int          minh = 0;
    int          maxh = 0;
    int          run = 0;
    int          valids = 0;
    int          valid_cyc = -1;
    int          fall_cyc = -1;

    assign ifc.ena_adc    = ena_drv[g];
    assign ifc.sdata      = sd;
    assign pot_o[g]       = ifc.pot;
    assign cs_o[g]        = ifc.cs_n;
    assign sclk_o[g]      = ifc.sclk;
    assign valid_o[g]     = ifc.pot_valid;
    assign busy_o[g]      = ifc.busy;
    assign rises_o[g]     = rises;
    assign minh_o[g]      = minh;
    assign maxh_o[g]      = maxh;
    assign valids_o[g]    = valids;
    assign valid_cyc_o[g] = valid_cyc;
    assign fall_cyc_o[g]  = fall_cyc;

    // ADC model: frame MSB presented when cs_n falls, next bit after each
    // observed sclk rise. Monitor measures sclk run lengths while cs_n is low.
    always @(negedge clk) begin
      prev_cs   <= ifc.cs_n;
      prev_sclk <= ifc.sclk;
      if (ifc.pot_valid) begin
        valids    <= valids + 1;
        valid_cyc <= cyc;
      end
      if (prev_cs && !ifc.cs_n) begin
        fr       <= frame_w[g];
        sd       <= frame_w[g][15];
        fall_cyc <= cyc;
        rises    <= 0;
        minh     <= 1000;
        maxh     <= 0;
        run      <= 1;
      end else if (!ifc.cs_n) begin
        if (ifc.sclk != prev_sclk) begin
          minh <= (run < minh) ? run : minh;
          maxh <= (run > maxh) ? run : maxh;
          run  <= 1;
          if (ifc.sclk) begin
            rises <= rises + 1;
            sd    <= fr[14];
            fr    <= fr << 1;
          end
        end else begin
          run <= run + 1;
        end
      end else if (!prev_cs) begin
        minh <= (run < minh) ? run : minh;
        maxh <= (run > maxh) ? run : maxh;
        run  <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to cycle c and settle just after its falling clock edge.
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  // One-cycle request on instance i; t0 is the cycle the edge register reads 1.
  task automatic pulse(input int i, output int t0);
    ena_drv[i] = 1'b1;
    t0 = cyc + 1;
    goto(t0);
    ena_drv[i] = 1'b0;
  endtask

  task automatic frame_check(input logic [15:0] frame, input logic [31:0] exp_pot);
    int t0;
    frame_w[0] = frame;
    pulse(0, t0);
    goto(t0 + 129);
    check("frame_valid", valid_o[0], 1);
    check("frame_pot", pot_o[0], exp_pot);
    goto(t0 + 138);
    check("frame_busy_end", busy_o[0], 0);
  endtask

  initial begin
    int t0;
    int v0;
    int v1;
    int v2;

    for (int i = 0; i < 3; i++) frame_w[i] = '0;
    rst     = 1'b0;
    ena_drv = '0;

    // Reset state
    goto(3);
    check("rst_cs_n", cs_o[0], 1);
    check("rst_sclk", sclk_o[0], 1);
    check("rst_pot", pot_o[0], 0);
    check("rst_valid", valid_o[0], 0);
    check("rst_busy", busy_o[0], 0);
    rst = 1'b1;
    goto(6);

    // Basic read, code 0xABC
    frame_w[0] = 16'h0ABC;
    v0 = valids_o[0];
    pulse(0, t0);
    check("c0_cs_n", cs_o[0], 1);
    check("c0_busy", busy_o[0], 0);
    goto(t0 + 1);
    check("c1_cs_n", cs_o[0], 0);
    check("c1_sclk", sclk_o[0], 0);
    check("c1_busy", busy_o[0], 1);
    check("cs_fall_cyc", fall_cyc_o[0] - t0, 1);
    goto(t0 + 128);
    check("c128_cs_n", cs_o[0], 0);
    check("c128_valid", valid_o[0], 0);
    goto(t0 + 129);
    check("c129_valid", valid_o[0], 1);
    check("c129_pot", pot_o[0], 32'h0ABC0);
    check("c129_cs_n", cs_o[0], 1);
    check("c129_sclk", sclk_o[0], 1);
    goto(t0 + 130);
    check("c130_valid", valid_o[0], 0);
    check("c130_pot_hold", pot_o[0], 32'h0ABC0);
    check("sclk_rises", rises_o[0], 16);
    check("half_min", minh_o[0], 4);
    check("half_max", maxh_o[0], 4);
    check("done_cyc", valid_cyc_o[0] - t0, 129);
    goto(t0 + 137);
    check("c137_busy", busy_o[0], 1);
    goto(t0 + 138);
    check("c138_busy", busy_o[0], 0);
    check("basic_valid_cnt", valids_o[0] - v0, 1);

    // Extremes; leading ones ignored
    frame_check(16'hF000, 32'h00000);
    frame_check(16'hFFFF, 32'h0FFF0);
    frame_check(16'h0000, 32'h00000);

    // Requests during busy are dropped
    frame_w[0] = 16'h0123;
    v0 = valids_o[0];
    pulse(0, t0);
    goto(t0 + 60);
    ena_drv[0] = 1'b1;
    goto(t0 + 61);
    ena_drv[0] = 1'b0;
    goto(t0 + 129);
    check("busy_pot1", pot_o[0], 32'h01230);
    goto(t0 + 135);
    ena_drv[0] = 1'b1;
    goto(t0 + 136);
    ena_drv[0] = 1'b0;
    goto(t0 + 139);
    check("busy_no_retrig_cs", cs_o[0], 1);
    check("busy_no_retrig_busy", busy_o[0], 0);
    goto(t0 + 140);
    frame_w[0] = 16'h0456;
    ena_drv[0] = 1'b1;
    goto(t0 + 141);
    ena_drv[0] = 1'b0;
    check("next_c0_cs_n", cs_o[0], 1);
    goto(t0 + 142);
    check("next_cs_n", cs_o[0], 0);
    check("next_fall_cyc", fall_cyc_o[0] - t0, 142);
    check("busy_valid_cnt", valids_o[0] - v0, 1);
    goto(t0 + 142 + 128);
    check("next_valid", valid_o[0], 1);
    check("next_pot", pot_o[0], 32'h04560);
    goto(t0 + 142 + 137);
    check("next_busy_end", busy_o[0], 0);
    check("busy_valid_cnt2", valids_o[0] - v0, 2);

    // Held request: exactly one frame
    frame_w[0] = 16'h0789;
    v0 = valids_o[0];
    ena_drv[0] = 1'b1;
    t0 = cyc + 1;
    goto(t0 + 1);
    check("held_cs_n", cs_o[0], 0);
    goto(t0 + 500);
    check("held_valid_cnt", valids_o[0] - v0, 1);
    check("held_busy", busy_o[0], 0);
    check("held_cs_idle", cs_o[0], 1);
    check("held_pot", pot_o[0], 32'h07890);
    ena_drv[0] = 1'b0;
    goto(t0 + 503);

    // Reset mid-frame
    frame_w[0] = 16'h0321;
    v0 = valids_o[0];
    pulse(0, t0);
    goto(t0 + 70);
    check("pre_rst_cs_n", cs_o[0], 0);
    rst = 1'b0;
    #1;
    check("async_cs_n", cs_o[0], 1);
    check("async_sclk", sclk_o[0], 1);
    check("async_pot", pot_o[0], 0);
    check("async_busy", busy_o[0], 0);
    goto(t0 + 73);
    rst = 1'b1;
    goto(t0 + 200);
    check("abort_no_valid", valids_o[0] - v0, 0);
    check("abort_pot", pot_o[0], 0);
    check("abort_cs_n", cs_o[0], 1);
    frame_check(16'h0DEF, 32'h0DEF0);

    // CLK_DIV sweep (instances 1 and 2)
    frame_w[1] = 16'h0A5A;
    frame_w[2] = 16'h0A5A;
    v1 = valids_o[1];
    v2 = valids_o[2];
    ena_drv[1] = 1'b1;
    ena_drv[2] = 1'b1;
    t0 = cyc + 1;
    goto(t0);
    ena_drv[1] = 1'b0;
    ena_drv[2] = 1'b0;
    goto(t0 + 33);
    check("div1_valid", valid_o[1], 1);
    check("div1_pot", pot_o[1], 32'h0A5A0);
    goto(t0 + 34);
    check("div1_done_cyc", valid_cyc_o[1] - t0, 33);
    check("div1_rises", rises_o[1], 16);
    check("div1_half_min", minh_o[1], 1);
    check("div1_half_max", maxh_o[1], 1);
    goto(t0 + 225);
    check("div7_valid", valid_o[2], 1);
    check("div7_pot", pot_o[2], 32'h0A5A0);
    goto(t0 + 226);
    check("div7_done_cyc", valid_cyc_o[2] - t0, 225);
    check("div7_rises", rises_o[2], 16);
    check("div7_half_min", minh_o[2], 7);
    check("div7_half_max", maxh_o[2], 7);
    goto(t0 + 240);
    check("div1_valid_cnt", valids_o[1] - v1, 1);
    check("div7_valid_cnt", valids_o[2] - v2, 1);
    check("div7_busy_end", busy_o[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
